// File: rtl/mmio_pkg.sv
// Shared register map, CTRL bit positions and prescaler width for the MMIO timer.
package mmio_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 12;
    localparam int PRESCALE_W = 8;

    typedef enum logic [3:0] {
        OFF_CTRL     = 4'd0,
        OFF_COUNT    = 4'd1,
        OFF_RELOAD   = 4'd2,
        OFF_STATUS   = 4'd3,
        OFF_PRESCALE = 4'd4
    } reg_off_t;

    localparam int CTRL_EN = 0;
    localparam int CTRL_AR = 1;
    localparam int CTRL_IE = 2;

    function automatic logic [DATA_W-1:0] ctrl_word(input logic en, input logic ar, input logic ie);
        ctrl_word = '0;
        ctrl_word[CTRL_EN] = en;
        ctrl_word[CTRL_AR] = ar;
        ctrl_word[CTRL_IE] = ie;
    endfunction

endpackage

// File: rtl/mmio_timer_tick_gen.sv
// Prescaler: pulses tick once every limit+1 enabled cycles.
module tick_gen
    import mmio_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] limit,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pcnt;

    assign tick = enable && (pcnt == limit);

    always_ff @(posedge clock) begin
        if (reset || clear || !enable) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer with prescaler, auto-reload and W1C expiry flag.
// Optional interrupt output enabled by defining MMIO_TIMER_IRQ_EN.
module mmio_timer
    import mmio_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hFF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    output logic [DATA_W-1:0] q,
    output logic              irq
);

    logic                  hit;
    logic [3:0]            offset;
    logic                  wr_ctrl, wr_count, wr_reload, wr_status, wr_presc;
    logic                  ctrl_en, ctrl_ar, ctrl_ie;
    logic                  ie_store;
    logic [DATA_W-1:0]     count, reload;
    logic                  expired;
    logic [PRESCALE_W-1:0] prescale;
    logic                  tick, expire;
    logic [DATA_W-1:0]     rd_data_p0;
    logic [DATA_W-1:0]     q_p1;

    assign hit       = (address[11:4] == BASE_ADDR);
    assign offset    = address[3:0];
    assign wr_ctrl   = hit && wren && (offset == OFF_CTRL);
    assign wr_count  = hit && wren && (offset == OFF_COUNT);
    assign wr_reload = hit && wren && (offset == OFF_RELOAD);
    assign wr_status = hit && wren && (offset == OFF_STATUS);
    assign wr_presc  = hit && wren && (offset == OFF_PRESCALE);

`ifdef MMIO_TIMER_IRQ_EN
    assign ie_store = data[CTRL_IE];
    assign irq      = expired & ctrl_ie;
`else
    assign ie_store = 1'b0;
    assign irq      = 1'b0;
`endif

    tick_gen u_tick_gen (
        .clock  (clock),
        .reset  (reset),
        .enable (ctrl_en),
        .clear  (wr_ctrl),
        .limit  (prescale),
        .tick   (tick)
    );

    assign expire = tick && (count == '0);

    always_comb begin
        rd_data_p0 = '0;
        if (hit) begin
            case (offset)
                OFF_CTRL:     rd_data_p0 = ctrl_word(ctrl_en, ctrl_ar, ctrl_ie);
                OFF_COUNT:    rd_data_p0 = count;
                OFF_RELOAD:   rd_data_p0 = reload;
                OFF_STATUS:   rd_data_p0 = {{(DATA_W-1){1'b0}}, expired};
                OFF_PRESCALE: rd_data_p0 = {{(DATA_W-PRESCALE_W){1'b0}}, prescale};
                default:      rd_data_p0 = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_en  <= 1'b0;
            ctrl_ar  <= 1'b0;
            ctrl_ie  <= 1'b0;
            count    <= '0;
            reload   <= '0;
            expired  <= 1'b0;
            prescale <= '0;
            q_p1     <= '0;
        end else begin
            // A one-shot expiry only beats a CTRL store that also leaves auto_reload off.
            if (wr_ctrl) begin
                ctrl_ar <= data[CTRL_AR];
                ctrl_ie <= ie_store;
                ctrl_en <= (expire && !ctrl_ar && !data[CTRL_AR]) ? 1'b0 : data[CTRL_EN];
            end else if (expire && !ctrl_ar) begin
                ctrl_en <= 1'b0;
            end

            if (wr_count) begin
                count <= data;
            end else if (tick) begin
                if (count != '0) begin
                    count <= count - 32'd1;
                end else if (ctrl_ar) begin
                    count <= reload;
                end
            end

            if (wr_reload) begin
                reload <= data;
            end
            if (wr_presc) begin
                prescale <= data[PRESCALE_W-1:0];
            end

            if (expire) begin
                expired <= 1'b1;
            end else if (wr_status && data[0]) begin
                expired <= 1'b0;
            end

            // Read stage: q carries the pre-write register value
            q_p1 <= rd_data_p0;
        end
    end

    assign q = q_p1;

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: directed scenarios plus randomized traffic vs a behavioural model.
module tb_mmio_timer;

    localparam logic [7:0] BASE = 8'hFF;
`ifdef MMIO_TIMER_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] address;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    mmio_timer #(.BASE_ADDR(BASE)) dut (
        .clock   (clock),
        .reset   (reset),
        .address (address),
        .data    (data),
        .wren    (wren),
        .q       (q),
        .irq     (irq)
    );

    typedef struct packed {
        logic        en;
        logic        ar;
        logic        ie;
        logic [31:0] count;
        logic [31:0] reload;
        logic        exp;
        logic [7:0]  presc;
        logic [7:0]  pc;
        logic [31:0] q;
    } model_t;

    model_t m;
    bit     primed = 1'b0;

    // Next state of the timer after one rising edge, from the register-level rules.
    function automatic model_t step(input model_t s, input logic rst, input logic [11:0] a,
                                    input logic w, input logic [31:0] d);
        model_t n;
        logic   hit, st, tk, fire;
        logic [3:0] off;
        if (rst) return '0;
        n    = s;
        hit  = (a[11:4] == BASE);
        off  = a[3:0];
        st   = hit && w;
        n.q  = 32'd0;
        if (hit) begin
            case (off)
                4'd0: n.q = {29'd0, s.ie, s.ar, s.en};
                4'd1: n.q = s.count;
                4'd2: n.q = s.reload;
                4'd3: n.q = {31'd0, s.exp};
                4'd4: n.q = {24'd0, s.presc};
                default: n.q = 32'd0;
            endcase
        end
        tk   = s.en && (s.pc == s.presc);
        fire = tk && (s.count == 0);
        if (!s.en || (st && off == 4'd0) || tk) n.pc = 8'd0;
        else n.pc = s.pc + 8'd1;
        if (tk) n.count = (s.count != 0) ? s.count - 1 : (s.ar ? s.reload : 32'd0);
        if (fire) begin
            n.exp = 1'b1;
            if (!s.ar) n.en = 1'b0;
        end
        if (st) begin
            case (off)
                4'd0: begin
                    n.ar = d[1];
                    n.ie = IRQ_ON ? d[2] : 1'b0;
                    n.en = (fire && !s.ar && !d[1]) ? 1'b0 : d[0];
                end
                4'd1: n.count = d;
                4'd2: n.reload = d;
                4'd3: if (d[0] && !fire) n.exp = 1'b0;
                4'd4: n.presc = d[7:0];
                default: ;
            endcase
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) begin
        m      <= step(m, reset, address, wren, data);
        primed <= 1'b1;
    end

    always @(negedge clock) begin
        if (primed) begin
            check("model_q", q, m.q);
            check("model_irq", {31'd0, irq}, {31'd0, IRQ_ON & m.exp & m.ie});
        end
    end

    function automatic logic [11:0] reg_addr(input logic [3:0] off);
        return {BASE, off};
    endfunction

    // Called at a falling edge; applies inputs for exactly one rising edge.
    task automatic drive(input logic [11:0] a, input logic w, input logic [31:0] d);
        address = a;
        wren    = w;
        data    = d;
        @(negedge clock);
    endtask

    initial begin
        logic [11:0] ra;
        logic [31:0] rd;
        reset   = 1'b1;
        address = 12'd0;
        data    = 32'd0;
        wren    = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            drive(reg_addr(4'(i)), 1'b0, 32'd0);
            check("reset_read", q, 32'd0);
            check("reset_irq", {31'd0, irq}, 32'd0);
        end

        // Auto-reload, PRESCALE=0: expiry every 4 edges
        drive(reg_addr(4'd4), 1'b1, 32'd0);
        drive(reg_addr(4'd2), 1'b1, 32'd3);
        drive(reg_addr(4'd1), 1'b1, 32'd3);
        drive(reg_addr(4'd0), 1'b1, 32'd3);
        repeat (3) drive(reg_addr(4'd3), 1'b0, 32'd0);
        drive(reg_addr(4'd3), 1'b0, 32'd0);
        check("ar_before_expiry", q, 32'd0);
        drive(reg_addr(4'd1), 1'b0, 32'd0);
        check("ar_count_reloaded", q, 32'd3);
        drive(reg_addr(4'd3), 1'b0, 32'd0);
        check("ar_expired", q, 32'd1);
        drive(reg_addr(4'd3), 1'b1, 32'd1);
        check("ar_w1c_prewrite", q, 32'd1);
        drive(reg_addr(4'd3), 1'b0, 32'd0);
        check("ar_cleared", q, 32'd0);
        drive(reg_addr(4'd3), 1'b0, 32'd0);
        check("ar_second_expiry", q, 32'd1);
        drive(reg_addr(4'd0), 1'b1, 32'd0);
        drive(reg_addr(4'd3), 1'b1, 32'd1);

        // One-shot, PRESCALE=2, COUNT=1: expiry at edge 6
        drive(reg_addr(4'd4), 1'b1, 32'd2);
        drive(reg_addr(4'd1), 1'b1, 32'd1);
        drive(reg_addr(4'd0), 1'b1, 32'd1);
        repeat (5) drive(reg_addr(4'd3), 1'b0, 32'd0);
        drive(reg_addr(4'd3), 1'b0, 32'd0);
        check("os_before_expiry", q, 32'd0);
        drive(reg_addr(4'd0), 1'b0, 32'd0);
        check("os_enable_cleared", q, 32'd0);
        drive(reg_addr(4'd3), 1'b0, 32'd0);
        check("os_expired", q, 32'd1);
        drive(reg_addr(4'd1), 1'b0, 32'd0);
        check("os_count_zero", q, 32'd0);

        // W1C colliding with expiry keeps the flag; a later W1C clears it
        drive(reg_addr(4'd3), 1'b1, 32'd1);
        drive(reg_addr(4'd4), 1'b1, 32'd0);
        drive(reg_addr(4'd0), 1'b1, 32'd1);
        drive(reg_addr(4'd3), 1'b1, 32'd1);
        drive(reg_addr(4'd3), 1'b1, 32'd1);
        check("w1c_collision_kept", q, 32'd1);
        drive(reg_addr(4'd3), 1'b0, 32'd0);
        check("w1c_later_cleared", q, 32'd0);

        // Miss and unmapped offsets
        drive(12'hEF0, 1'b1, 32'd5);
        check("miss_q", q, 32'd0);
        drive(reg_addr(4'd7), 1'b0, 32'd0);
        check("unmapped_q", q, 32'd0);
        drive(reg_addr(4'd0), 1'b0, 32'd0);
        check("miss_ctrl_unchanged", q, 32'd0);

        // Interrupt enable bit
        drive(reg_addr(4'd1), 1'b1, 32'd0);
        drive(reg_addr(4'd0), 1'b1, 32'd7);
        drive(reg_addr(4'd0), 1'b0, 32'd0);
        check("ctrl7_readback", q, IRQ_ON ? 32'd7 : 32'd3);
        check("irq_on_expiry", {31'd0, irq}, {31'd0, IRQ_ON});
        drive(reg_addr(4'd3), 1'b0, 32'd0);
        check("irq_held", {31'd0, irq}, {31'd0, IRQ_ON});
        drive(reg_addr(4'd3), 1'b1, 32'd1);
        check("irq_after_w1c", {31'd0, irq}, 32'd0);

        // Randomized traffic, including resets mid-countdown
        for (int i = 0; i < 4000; i++) begin
            int r;
            reset = ($urandom_range(0, 149) == 0);
            r = int'($urandom_range(0, 9));
            if (r < 7) ra = {BASE, 1'b0, 3'($urandom_range(0, 7))};
            else if (r < 8) ra = {BASE, 4'($urandom_range(8, 15))};
            else ra = 12'($urandom);
            if ($urandom_range(0, 9) == 0) rd = $urandom;
            else rd = 32'($urandom_range(0, 6));
            drive(ra, ($urandom_range(0, 2) == 0), rd);
        end
        reset = 1'b0;
        drive(12'd0, 1'b0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
